// File: rtl/fir_y_sink_if.sv
// rtl/fir_y_sink_if.sv - stream and flag signals between fir_16tap output and downstream logic
interface fir_y_sink_if #(
    parameter int IN_W  = 34,
    parameter int OUT_W = 16
);
    logic             y_valid;
    logic [IN_W-1:0]  y;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_sat;
    logic             settled;
    logic             overflow;
    logic             clear_flags;

    modport slave (
        input  y_valid, y, out_ready, clear_flags,
        output out_valid, out_data, out_sat, settled, overflow
    );

    modport master (
        output y_valid, y, out_ready, clear_flags,
        input  out_valid, out_data, out_sat, settled, overflow
    );
endinterface

// File: rtl/fir_y_sink.sv
// rtl/fir_y_sink.sv - round/saturate filter output, buffer in a show-ahead FIFO, flag settling and drops
module fir_y_sink #(
    parameter int IN_W       = 34,
    parameter int OUT_W      = 16,
    parameter int SHIFT      = 15,
    parameter int DEPTH      = 4,
    parameter int SETTLE_CNT = 16
) (
    input logic          clk,
    input logic          reset,
    fir_y_sink_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(SETTLE_CNT);
    localparam logic signed [IN_W:0] RND  = (IN_W+1)'(1) << (SHIFT-1);
    localparam logic signed [IN_W:0] MAXV = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] MINV = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [IN_W:0] y_ext;
    logic signed [IN_W:0] r;
    logic [OUT_W-1:0]     rnd_data;
    logic                 rnd_sat;

    logic             s1_valid;
    logic [OUT_W-1:0] s1_data;
    logic             s1_sat;

    logic [OUT_W:0]   mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             full, push, pop, drop;

    logic [OUT_W-1:0] prev;
    logic             prev_vld;
    logic [CW-1:0]    cnt;

    // Sign-extend by one bit so adding the half-LSB cannot wrap at the positive limit.
    assign y_ext = {bus.y[IN_W-1], bus.y};
    assign r     = (y_ext + RND) >>> SHIFT;

    always_comb begin
        rnd_data = r[OUT_W-1:0];
        rnd_sat  = 1'b0;
        if (r > MAXV) begin
            rnd_data = MAXV[OUT_W-1:0];
            rnd_sat  = 1'b1;
        end else if (r < MINV) begin
            rnd_data = MINV[OUT_W-1:0];
            rnd_sat  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_sat   <= 1'b0;
        end else begin
            s1_valid <= bus.y_valid;
            if (bus.y_valid) begin
                s1_data <= rnd_data;
                s1_sat  <= rnd_sat;
            end
        end
    end

    assign full          = (count == (AW+1)'(DEPTH));
    assign bus.out_valid = (count != '0);
    assign pop           = bus.out_valid & bus.out_ready;
    assign push          = s1_valid & (~full | pop);
    assign drop          = s1_valid & full & ~pop;
    assign {bus.out_sat, bus.out_data} = mem[rd_ptr];

    // RAM is reset so the head reads as zero rather than X while empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {s1_sat, s1_data};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Settling looks at every stage-1 word, including ones the FIFO drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev     <= '0;
            prev_vld <= 1'b0;
            cnt      <= '0;
        end else if (bus.clear_flags) begin
            prev_vld <= 1'b0;
            cnt      <= '0;
        end else if (s1_valid) begin
            prev     <= s1_data;
            prev_vld <= 1'b1;
            if (prev_vld && s1_data == prev) begin
                if (cnt != CW'(SETTLE_CNT-1)) cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

    assign bus.settled = (cnt == CW'(SETTLE_CNT-1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) bus.overflow <= 1'b0;
        else       bus.overflow <= (bus.overflow & ~bus.clear_flags) | drop;
    end
endmodule

// File: tb/tb_fir_y_sink.sv
// tb/tb_fir_y_sink.sv - directed self-checking bench for fir_y_sink
module tb_fir_y_sink;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    fir_y_sink_if #(.IN_W(34), .OUT_W(16)) bus ();

    fir_y_sink #(
        .IN_W(34), .OUT_W(16), .SHIFT(15), .DEPTH(4), .SETTLE_CNT(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.y_valid = 0; bus.y = '0; bus.out_ready = 0; bus.clear_flags = 0;
        reset = 1;
        step(); step();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 16'd0 || bus.out_sat !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: valid=%b data=%h sat=%b required 0/0000/0", bus.out_valid, bus.out_data, bus.out_sat);
        end
        n_checks++;
        if (bus.settled !== 1'b0 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: settled=%b overflow=%b required 0/0", bus.settled, bus.overflow);
        end
        reset = 0;
        step();
    endtask

    task automatic test_rounding();
        logic [33:0] yv [5];
        logic [15:0] ev [5];
        yv[0] = 34'd32768;      ev[0] = 16'd1;
        yv[1] = 34'd16384;      ev[1] = 16'd1;
        yv[2] = 34'd16383;      ev[2] = 16'd0;
        yv[3] = 34'(-16384);    ev[3] = 16'd0;
        yv[4] = 34'(-16385);    ev[4] = 16'hFFFF;
        bus.out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            bus.y = yv[i]; bus.y_valid = 1;
            step();
            bus.y_valid = 0;
            n_checks++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL round_latency%0d: out_valid=%b one cycle after input, required 0", i, bus.out_valid);
            end
            step();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== ev[i] || bus.out_sat !== 1'b0) begin
                n_fail++;
                $display("FAIL round%0d: valid=%b data=%h sat=%b required 1/%h/0", i, bus.out_valid, bus.out_data, bus.out_sat, ev[i]);
            end
            step();
        end
    endtask

    task automatic test_saturation();
        logic [33:0] yv [2];
        logic [15:0] ev [2];
        yv[0] = 34'h0_8000_0000; ev[0] = 16'h7FFF;
        yv[1] = 34'h2_0000_0000; ev[1] = 16'h8000;
        bus.out_ready = 1;
        for (int i = 0; i < 2; i++) begin
            bus.y = yv[i]; bus.y_valid = 1;
            step();
            bus.y_valid = 0;
            step();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== ev[i] || bus.out_sat !== 1'b1) begin
                n_fail++;
                $display("FAIL sat%0d: valid=%b data=%h sat=%b required 1/%h/1", i, bus.out_valid, bus.out_data, bus.out_sat, ev[i]);
            end
            step();
        end
    endtask

    task automatic test_full_push_pop();
        int exp_k = 1;
        bus.out_ready = 0;
        for (int k = 1; k <= 10; k++) begin
            bus.y = 34'(k * 32768); bus.y_valid = 1;
            if (k == 6) bus.out_ready = 1;
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                if (bus.out_data !== 16'(exp_k)) begin
                    n_fail++;
                    $display("FAIL fullpp_order: data=%0d required %0d", bus.out_data, exp_k);
                end
                exp_k++;
            end
            step();
        end
        bus.y_valid = 0;
        for (int i = 0; i < 20 && exp_k <= 10; i++) begin
            if (bus.out_valid) begin
                n_checks++;
                if (bus.out_data !== 16'(exp_k)) begin
                    n_fail++;
                    $display("FAIL fullpp_order: data=%0d required %0d", bus.out_data, exp_k);
                end
                exp_k++;
            end
            step();
        end
        n_checks++;
        if (exp_k != 11) begin
            n_fail++;
            $display("FAIL fullpp_count: received %0d words required 10", exp_k - 1);
        end
        n_checks++;
        if (bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fullpp_overflow: overflow=%b required 0", bus.overflow);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 0;
        for (int k = 1; k <= 6; k++) begin
            bus.y = 34'(k * 32768); bus.y_valid = 1;
            step();
            if (k == 5) begin
                n_checks++;
                if (bus.overflow !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_overflow_early: overflow=%b required 0", bus.overflow);
                end
            end
            if (k == 6) begin
                n_checks++;
                if (bus.overflow !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_overflow: overflow=%b required 1", bus.overflow);
                end
            end
        end
        bus.y_valid = 0;
        step();
        bus.out_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 16'(i)) begin
                n_fail++;
                $display("FAIL bp_drain%0d: valid=%b data=%0d required 1/%0d", i, bus.out_valid, bus.out_data, i);
            end
            step();
        end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_empty: out_valid=%b required 0", bus.out_valid);
        end
    endtask

    task automatic test_settling();
        bus.out_ready = 1;
        for (int k = 1; k <= 20; k++) begin
            bus.y = 34'(5 * 32768); bus.y_valid = 1;
            step();
            if (k == 16) begin
                n_checks++;
                if (bus.settled !== 1'b0) begin
                    n_fail++;
                    $display("FAIL settle_early: settled=%b after 15 equal words required 0", bus.settled);
                end
            end
            if (k == 17) begin
                n_checks++;
                if (bus.settled !== 1'b1) begin
                    n_fail++;
                    $display("FAIL settle: settled=%b after 16 equal words required 1", bus.settled);
                end
            end
        end
        bus.y = 34'(6 * 32768);
        step();
        bus.y_valid = 0;
        n_checks++;
        if (bus.settled !== 1'b1) begin
            n_fail++;
            $display("FAIL settle_hold: settled=%b required 1", bus.settled);
        end
        step();
        n_checks++;
        if (bus.settled !== 1'b0) begin
            n_fail++;
            $display("FAIL settle_break: settled=%b required 0", bus.settled);
        end
        step();
    endtask

    task automatic test_flags();
        bus.clear_flags = 1;
        step();
        bus.clear_flags = 0;
        n_checks++;
        if (bus.overflow !== 1'b0 || bus.settled !== 1'b0) begin
            n_fail++;
            $display("FAIL clear1: overflow=%b settled=%b required 0/0", bus.overflow, bus.settled);
        end
        bus.out_ready = 1;
        bus.y = 34'(7 * 32768); bus.y_valid = 1;
        for (int k = 0; k < 16; k++) step();
        bus.out_ready = 0;
        for (int k = 0; k < 6; k++) step();
        bus.y_valid = 0;
        step(); step();
        n_checks++;
        if (bus.overflow !== 1'b1 || bus.settled !== 1'b1) begin
            n_fail++;
            $display("FAIL flags_set: overflow=%b settled=%b required 1/1", bus.overflow, bus.settled);
        end
        bus.clear_flags = 1;
        step();
        bus.clear_flags = 0;
        n_checks++;
        if (bus.overflow !== 1'b0 || bus.settled !== 1'b0) begin
            n_fail++;
            $display("FAIL clear2: overflow=%b settled=%b required 0/0", bus.overflow, bus.settled);
        end
    endtask

    task automatic test_midstream_reset();
        bus.out_ready = 1;
        for (int i = 0; i < 8 && bus.out_valid; i++) step();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_predrain: out_valid=%b required 0", bus.out_valid);
        end
        bus.out_ready = 0;
        for (int k = 1; k <= 3; k++) begin
            bus.y = 34'(k * 32768); bus.y_valid = 1;
            step();
        end
        bus.y_valid = 0;
        step(); step();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd1) begin
            n_fail++;
            $display("FAIL rst_buffered: valid=%b data=%0d required 1/1", bus.out_valid, bus.out_data);
        end
        #2 reset = 1;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_async: valid=%b data=%h required 0/0000", bus.out_valid, bus.out_data);
        end
        step();
        reset = 0;
        bus.out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_no_output%0d: out_valid=%b required 0", i, bus.out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_saturation();
        test_full_push_pop();
        test_backpressure();
        test_settling();
        test_flags();
        test_midstream_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fir_y_sink.md
# fir_y_sink

Output-side receiver for the `fir_16tap` result stream. It takes the full-precision 34-bit filter output `y` with a valid strobe. Each sample is rounded and saturated to a 16-bit signed word and buffered in a small FIFO with a ready/valid handshake to downstream logic. It also reports step-response settling and drop/saturation events. It sits directly after the filter, which has no backpressure.

## Interface
Parameters:
- `IN_W`, 34, width of filter output `y` (signed two's complement)
- `OUT_W`, 16, width of rounded output word (signed)
- `SHIFT`, 15, right-shift applied before rounding; legal range 1..IN_W-OUT_W
- `DEPTH`, 4, FIFO depth in words; power of two, ≥2
- `SETTLE_CNT`, 16, consecutive equal samples needed to declare settled; ≥2

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `y_valid`  in  1  `y` carries a new sample this cycle
- `y`  in  IN_W  filter output sample
- `out_valid`  out  1  `out_data`/`out_sat` hold the FIFO head
- `out_ready`  in  1  downstream accepts the head this cycle
- `out_data`  out  OUT_W  rounded/saturated sample
- `out_sat`  out  1  head sample was saturated
- `settled`  out  1  last SETTLE_CNT accepted samples were equal
- `overflow`  out  1  sticky: at least one sample dropped since the last clear
- `clear_flags`  in  1  clears `overflow` and `settled` history

## Operation
- Stage 1, registered on `y_valid`:
  - r = (y + 2^(SHIFT-1)) >>> SHIFT, computed in IN_W+1 bits. Rounding is round-half-up toward +inf.
  - If r > 2^(OUT_W-1)-1, store 32767 with sat=1.
  - If r < -2^(OUT_W-1), store -32768 with sat=1.
  - Otherwise store r[OUT_W-1:0] with sat=0.
  - `s1_valid` follows `y_valid` one cycle later.
- FIFO: DEPTH entries of {sat, data}, show-ahead. Head is visible on `out_data` whenever `out_valid`=1.
  - Push when `s1_valid`=1 and (not full, or pop in the same cycle).
  - Pop when `out_valid` & `out_ready`.
  - Full with no pop: the stage-1 word is dropped and `overflow` sets. FIFO contents are unchanged.
  - Simultaneous push and pop when full: both happen; no drop; occupancy is unchanged.
  - Simultaneous push and pop when empty: not possible, because `out_valid`=0.
  - Pointers wrap modulo DEPTH. Occupancy counter runs 0..DEPTH.
- Settle detector operates on every `s1_valid` word, dropped or not:
  - First word after reset or `clear_flags`: cnt=0, store the word as `prev`.
  - Later words: if word == `prev`, cnt = min(cnt+1, SETTLE_CNT-1); else cnt=0. `prev` is always updated to the new word.
  - `settled` = (cnt == SETTLE_CNT-1).
- `clear_flags` clears `overflow`, cnt and the `prev`-valid bit. If a drop occurs in the same cycle, `overflow` ends at 1.
- `out_data` and `out_sat` are don't-care while `out_valid`=0, but are driven from the RAM head with no X.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_sat`=0, `settled`=0, `overflow`=0, FIFO empty, cnt=0, `s1_valid`=0.
- Reset asserted mid-stream: all buffered words are discarded immediately (asynchronous). The first `y_valid` after deassertion is handled as a fresh sample.
- Latency: `y_valid` sampled at edge N gives `s1_valid` after N, pushes at N+1, and `out_valid`=1 after N+1 if the FIFO was empty. That is a 2-cycle latency.
- Throughput: one sample per clock in and out. `out_ready` held at 1 never causes a drop.
- `settled` updates at the edge where the SETTLE_CNT-th equal word is in stage 1, which is edge N+1 for a sample at edge N.
- `overflow` sets at the edge where the drop occurs.

## Test plan
- Rounding: `y`=32768, 16384, 16383, -16384, -16385 with `out_ready`=1 → `out_data`=1, 1, 0, 0, -1; all `out_sat`=0; each appears 2 cycles after input.
- Saturation: `y`=2^31, then -2^33 → `out_data`=32767 with `out_sat`=1, then -32768 with `out_sat`=1.
- Backpressure/drop: `out_ready`=0, six back-to-back samples 1..6 (scaled ×32768) → FIFO holds 1..4, `overflow`=1 after the 5th. Then raise `out_ready` → 1,2,3,4 drain in order, `out_valid` falls.
- Full push+pop: FIFO full, `out_ready`=1 with a continuous input stream → no drop, `overflow` stays 0, output order preserved.
- Settling: feed 20 identical samples of 5×32768 → `settled`=1 after the 16th. Then feed 6×32768 → `settled`=0 the next cycle.
- Flags and reset: `overflow`=1 and `settled`=1, pulse `clear_flags` → both 0. Assert `reset` with 3 words buffered → `out_valid`=0 immediately, and there is no output after release.
